sparse_entry_fifo: RTL and testbench

- Parametrised first-word-fall-through FIFO for packed sparse-matrix entries (row/col/value words) between the loader and the multiply datapath.
- Replaces the fixed 64 x 136 buffer. Adds:
  - configurable width and depth;
  - valid/ready handshakes on both sides;
  - occupancy flags;
  - a mark/rewind mode, so one row's entries can be replayed for each column pass without reloading them.

---
 rtl/sparse_entry_fifo.sv | 78 +++++++
 tb/tb_sparse_entry_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_entry_fifo.sv
// First-word-fall-through FIFO for packed sparse-matrix entries with a
// mark/rewind replay window so a row can be re-read once per column pass.
module sparse_entry_fifo #(
  parameter  int DATA_W   = 136,
  parameter  int DEPTH    = 64,
  parameter  int AFULL_TH = 60,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              mark,
  input  logic              rewind,
  // "release" is a reserved word, hence the longer name
  input  logic              release_mark,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              mark_active
);

  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AFULL_V = (PTR_W+1)'(AFULL_TH);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr, mark_ptr;
  logic [PTR_W:0]    base, occ, rd_post;
  logic              push, pop, do_rewind;

  // Occupancy is measured from the replay point while marked, so popped
  // entries inside the window stay protected from overwrite.
  assign base        = mark_active ? mark_ptr : rd_ptr;
  assign occ         = wr_ptr - base;
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (occ == DEPTH_V);
  assign almost_full = (occ >= AFULL_V);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : ram[rd_ptr[PTR_W-1:0]];

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign do_rewind = rewind && mark_active;
  assign rd_post   = rd_ptr + (PTR_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr[PTR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mark_ptr    <= '0;
      mark_active <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // rewind discards a same-cycle pop and outranks release/mark
      rd_ptr <= do_rewind ? mark_ptr : rd_post;
      if (do_rewind) begin
        if (release_mark) mark_active <= 1'b0;
      end else if (mark) begin
        mark_ptr    <= rd_post;
        mark_active <= 1'b1;
      end else if (release_mark) begin
        mark_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sparse_entry_fifo.sv
// Scoreboard bench for sparse_entry_fifo: ordering, flags, replay and reset.
module tb_sparse_entry_fifo;
  localparam int DATA_W = 136;
  localparam int DEPTH  = 64;
  localparam int PTR_W  = 6;

  logic              clk = 0, resetn = 0;
  logic              in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [DATA_W-1:0] in_data = '0, out_data;
  logic              mark = 0, rewind = 0, release_mark = 0;
  logic [PTR_W:0]    count;
  logic              empty, full, almost_full, mark_active;

  sparse_entry_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(60)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mark(mark), .rewind(rewind), .release_mark(release_mark),
    .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .mark_active(mark_active)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DATA_W-1:0] q[$];
  logic sb_on = 1, acc_in, acc_out;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sample handshakes mid-cycle, then advance one edge
  task automatic step();
    @(negedge clk);
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    if (sb_on) begin
      if (acc_out) begin
        if (q.size() == 0) chk("sb_underrun", 1, 0);
        else chk("sb_data", out_data, q.pop_front());
      end
      if (acc_in) q.push_back(in_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; mark = 0; rewind = 0; release_mark = 0;
  endtask

  task automatic drain();
    idle(); out_ready = 1;
    for (int i = 0; i < 300 && !empty; i++) step();
    out_ready = 0;
    chk("drain_empty", empty, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_mark_active"}, mark_active, 0);
  endtask

  initial begin
    int nxt, rcv, maxc;
    #12 resetn = 1;
    @(posedge clk); #1;
    chk_reset("rst");

    // back-to-back pushes, consumer stalled
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_data = DATA_W'(i);
      step();
      chk("bb_count", count, DATA_W'(i));
      if (i == 1) begin
        chk("bb_head", out_data, 1);
        chk("bb_empty", empty, 0);
      end
    end
    drain();

    // fill to full, then push+pop while full
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = DATA_W'(i + 'h100);
      step();
      if (i == 58 || i == 59) chk("fill_afull", almost_full, (i >= 59));
      if (i == 62 || i == 63) chk("fill_full", full, (i == 63));
    end
    chk("fill_in_ready", in_ready, 0);
    in_valid = 1; in_data = 'hDEAD; out_ready = 1;
    step();
    idle();
    chk("fullpp_count", count, 63);
    chk("fullpp_in_ready", in_ready, 1);
    drain();
    chk("fill_sb_empty", q.size(), 0);

    // random stream across pointer wraps
    nxt = 0; rcv = 0; maxc = 0;
    for (int c = 0; c < 4000 && rcv < 200; c++) begin
      in_valid  = (nxt < 200) && ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'(nxt);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (acc_in) nxt++;
      if (acc_out) rcv++;
      if (int'(count) > maxc) maxc = int'(count);
    end
    idle();
    chk("stream_rcv", rcv, 200);
    chk("stream_sb_empty", q.size(), 0);
    chk("stream_maxcount_ok", (maxc <= DEPTH), 1);

    // mark / replay / release
    sb_on = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = DATA_W'('hA0 + i); step();
    end
    idle(); mark = 1; step(); mark = 0;
    chk("mk_active", mark_active, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("mk_pop1", out_data, DATA_W'('hA0 + i)); step();
    end
    out_ready = 0;
    chk("mk_empty", empty, 1);
    rewind = 1; step(); rewind = 0;
    chk("rw_head", out_data, 'hA0);
    chk("rw_count", count, 8);
    chk("rw_active", mark_active, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("rw_pop2", out_data, DATA_W'('hA0 + i)); step();
    end
    idle(); release_mark = 1; step(); release_mark = 0;
    chk("rel_active", mark_active, 0);
    chk("rel_in_ready", in_ready, 1);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_data = DATA_W'('h500 + i); step();
      if (i == 62 || i == 63) chk("rel_fill_full", full, (i == 63));
    end

    // marked window protects popped entries
    idle(); mark = 1; step(); mark = 0;
    out_ready = 1;
    for (int i = 0; i < 10; i++) step();
    out_ready = 0;
    chk("prot_count", count, 54);
    chk("prot_full", full, 1);
    chk("prot_in_ready", in_ready, 0);
    release_mark = 1; step(); release_mark = 0;
    chk("prot_rel_in_ready", in_ready, 1);
    chk("prot_rel_full", full, 0);

    // rewind+release together, then reset mid-rewind
    resetn = 0; #2 resetn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_data = DATA_W'('hC00 + i); step();
    end
    idle(); mark = 1; step(); mark = 0;
    out_ready = 1; for (int i = 0; i < 5; i++) step(); out_ready = 0;
    rewind = 1; release_mark = 1; step(); rewind = 0; release_mark = 0;
    chk("rwrel_head", out_data, 'hC00);
    chk("rwrel_count", count, 20);
    chk("rwrel_active", mark_active, 0);
    mark = 1; step(); mark = 0;
    out_ready = 1; for (int i = 0; i < 5; i++) step(); out_ready = 0;
    rewind = 1; out_ready = 1;
    resetn = 0; #2;
    chk_reset("async");
    idle();
    #1 resetn = 1;
    in_valid = 1; in_data = 'h77;
    step();
    idle();
    chk("post_rst_head", out_data, 'h77);
    chk("post_rst_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
